// File: rtl/bias_pkg.sv
// Shared definitions for the bias fetch sequencer: default widths and
// the state encodings of the main FSM and the prefetch sub-FSM.
package bias_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    // Main job FSM
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Prefetch of the next column pair while tiles are running
    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_RD1  = 2'd1,
        PF_RD2  = 2'd2,
        PF_WAIT = 2'd3
    } pf_e;

endpackage

// File: rtl/bias_fetch_seq_lane.sv
// Per-lane tile tracker: counts systolic valids, detects tile ends,
// generates the column load pulse (directly or after waiting for staging)
// and flags protocol violations seen on this lane.
module bias_lane_tracker
    import bias_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              init_load,
    input  logic [DATA_W-1:0] init_val,
    input  logic [CNT_W-1:0]  rows_per_tile,
    input  logic [CNT_W-1:0]  num_tiles,
    input  logic              sys_valid,
    input  logic              stg_avail,
    input  logic [DATA_W-1:0] stg_val,
    output logic              load_en,
    output logic [DATA_W-1:0] bias_out,
    output logic              consume,
    output logic              fin_next,
    output logic              err_set
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0]  row_cnt_r;
    logic [CNT_W-1:0]  tiles_done_r;
    logic              pending_r;
    logic              finished_r;
    logic              load_en_r;
    logic [DATA_W-1:0] bias_out_r;

    logic count_s;
    logic tile_end_s;
    logic last_tile_s;
    logic need_load_s;
    logic fire_s;

    // Decode valid counting, tile end and when this lane loads its next bias
    always_comb begin
        count_s     = 1'b0;
        tile_end_s  = 1'b0;
        last_tile_s = 1'b0;
        need_load_s = 1'b0;
        fire_s      = 1'b0;
        count_s     = run & sys_valid & ~finished_r;
        tile_end_s  = count_s & (row_cnt_r == (rows_per_tile - CNT_ONE));
        last_tile_s = (tiles_done_r == (num_tiles - CNT_ONE));
        need_load_s = tile_end_s & ~last_tile_s;
        // A late staging is served the first cycle it becomes available
        fire_s      = (need_load_s | pending_r) & stg_avail;
    end

    // Lane counters, pending flag and registered load pulse / bias value
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_r    <= CNT_ZERO;
            tiles_done_r <= CNT_ZERO;
            pending_r    <= 1'b0;
            finished_r   <= 1'b0;
            load_en_r    <= 1'b0;
            bias_out_r   <= {DATA_W{1'b0}};
        end else if (init_load) begin
            row_cnt_r    <= CNT_ZERO;
            tiles_done_r <= CNT_ZERO;
            pending_r    <= 1'b0;
            finished_r   <= 1'b0;
            load_en_r    <= 1'b1;
            bias_out_r   <= init_val;
        end else begin
            load_en_r <= fire_s;
            if (fire_s) begin
                bias_out_r <= stg_val;
            end
            if (count_s) begin
                row_cnt_r <= tile_end_s ? CNT_ZERO : (row_cnt_r + CNT_ONE);
            end
            if (tile_end_s) begin
                tiles_done_r <= tiles_done_r + CNT_ONE;
            end
            if (tile_end_s & last_tile_s) begin
                finished_r <= 1'b1;
            end
            if (fire_s) begin
                pending_r <= 1'b0;
            end else if (need_load_s) begin
                pending_r <= 1'b1;
            end
        end
    end

    assign load_en  = load_en_r;
    assign bias_out = bias_out_r;
    assign consume  = fire_s;
    assign fin_next = finished_r | (tile_end_s & last_tile_s);
    // Valid outside RUN, after the last tile, in the load cycle or while waiting
    assign err_set  = sys_valid & (~run | finished_r | load_en_r | pending_r);

endmodule

// File: rtl/bias_fetch_seq.sv
// Bias fetch sequencer: reads one bias per column from the Unified Buffer,
// stages the next column pair, and pulses each column's load enable at the
// start of every neuron tile as tracked from the systolic valid strobes.
module bias_fetch_seq
    import bias_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_tiles,
    input  logic [CNT_W-1:0]  rows_per_tile,
    output logic              busy,
    output logic              done,
    output logic              protocol_err,
    output logic              ub_rd_en,
    output logic [ADDR_W-1:0] ub_rd_addr,
    input  logic [DATA_W-1:0] ub_rd_data,
    input  logic              sys_valid_mon_1,
    input  logic              sys_valid_mon_2,
    output logic [DATA_W-1:0] bias_scalar_ub_out_1,
    output logic [DATA_W-1:0] bias_scalar_ub_out_2,
    output logic              bias_load_en_1,
    output logic              bias_load_en_2
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_TWO = {{(ADDR_W-2){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    state_e            state_r;
    pf_e               pf_r;
    logic [1:0]        fph_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] next_addr_r;
    logic [CNT_W-1:0]  num_tiles_r;
    logic [CNT_W-1:0]  rows_r;
    logic [CNT_W-1:0]  fetch_tile_r;
    logic [DATA_W-1:0] stage1_r;
    logic [DATA_W-1:0] stage2_r;
    logic              stg_valid_r;
    logic              used_1_r;
    logic              used_2_r;

    logic              start_acc_s;
    logic              launch_s;
    logic              run_s;
    logic              init_load_s;
    logic              stg_avail_s;
    logic              avail_1_s;
    logic              avail_2_s;
    logic              pf_go_s;
    logic              both_used_s;
    logic [DATA_W-1:0] stg_val_2_s;
    logic              consume_1_s;
    logic              consume_2_s;
    logic              fin_1_s;
    logic              fin_2_s;
    logic              err_1_s;
    logic              err_2_s;

    // Command acceptance, staging availability and prefetch trigger decode
    always_comb begin
        start_acc_s = 1'b0;
        launch_s    = 1'b0;
        run_s       = 1'b0;
        init_load_s = 1'b0;
        stg_avail_s = 1'b0;
        pf_go_s     = 1'b0;
        stg_val_2_s = {DATA_W{1'b0}};
        start_acc_s = start & ~busy_r;
        launch_s    = start_acc_s & (num_tiles != CNT_ZERO) & (rows_per_tile != CNT_ZERO);
        run_s       = (state_r == RUN);
        init_load_s = (state_r == FETCH0) && (fph_r == 2'd2);
        // Second prefetch word counts as staged in the cycle it arrives
        stg_avail_s = stg_valid_r | (pf_r == PF_WAIT);
        if (stg_valid_r) begin
            stg_val_2_s = stage2_r;
        end else begin
            stg_val_2_s = ub_rd_data;
        end
        pf_go_s = ((state_r == ARM) || (state_r == RUN)) && (pf_r == PF_IDLE) &&
                  !stg_valid_r && (fetch_tile_r < num_tiles_r);
    end

    assign avail_1_s   = stg_avail_s & ~used_1_r;
    assign avail_2_s   = stg_avail_s & ~used_2_r;
    assign both_used_s = (used_1_r | consume_1_s) & (used_2_r | consume_2_s);

    // Main job FSM: launch, initial fetch phases, arm, run and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            fph_r       <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            num_tiles_r <= CNT_ZERO;
            rows_r      <= CNT_ZERO;
        end else begin
            done_r <= 1'b0;
            if (start_acc_s) begin
                num_tiles_r <= num_tiles;
                rows_r      <= rows_per_tile;
                fph_r       <= 2'd0;
                if (launch_s) begin
                    state_r <= FETCH0;
                    busy_r  <= 1'b1;
                end else begin
                    // Empty job completes at once without touching the UB
                    state_r <= IDLE;
                    done_r  <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    FETCH0: begin
                        if (fph_r == 2'd2) begin
                            state_r <= ARM;
                        end else begin
                            fph_r <= fph_r + 2'd1;
                        end
                    end
                    ARM: begin
                        state_r <= RUN;
                    end
                    RUN: begin
                        if (fin_1_s && fin_2_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // UB read port: initial pair fetch, then background prefetch of later pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r      <= 1'b0;
            rd_addr_r    <= {ADDR_W{1'b0}};
            next_addr_r  <= {ADDR_W{1'b0}};
            fetch_tile_r <= CNT_ZERO;
            pf_r         <= PF_IDLE;
            stage1_r     <= {DATA_W{1'b0}};
            stage2_r     <= {DATA_W{1'b0}};
        end else if (launch_s) begin
            rd_en_r      <= 1'b1;
            rd_addr_r    <= base_addr;
            next_addr_r  <= base_addr + ADDR_TWO;
            fetch_tile_r <= CNT_ONE;
            pf_r         <= PF_IDLE;
        end else if (state_r == FETCH0) begin
            case (fph_r)
                2'd0: begin
                    rd_addr_r <= rd_addr_r + ADDR_ONE;
                end
                2'd1: begin
                    rd_en_r  <= 1'b0;
                    stage1_r <= ub_rd_data;
                end
                default: begin
                    rd_en_r <= 1'b0;
                end
            endcase
        end else begin
            case (pf_r)
                PF_IDLE: begin
                    if (pf_go_s) begin
                        rd_en_r      <= 1'b1;
                        rd_addr_r    <= next_addr_r;
                        next_addr_r  <= next_addr_r + ADDR_TWO;
                        fetch_tile_r <= fetch_tile_r + CNT_ONE;
                        pf_r         <= PF_RD1;
                    end
                end
                PF_RD1: begin
                    rd_addr_r <= rd_addr_r + ADDR_ONE;
                    pf_r      <= PF_RD2;
                end
                PF_RD2: begin
                    rd_en_r  <= 1'b0;
                    stage1_r <= ub_rd_data;
                    pf_r     <= PF_WAIT;
                end
                PF_WAIT: begin
                    stage2_r <= ub_rd_data;
                    pf_r     <= PF_IDLE;
                end
                default: begin
                    rd_en_r <= 1'b0;
                    pf_r    <= PF_IDLE;
                end
            endcase
        end
    end

    // Staging ownership: valid after the second prefetch word, freed once both lanes used it
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_r <= 1'b0;
            used_1_r    <= 1'b0;
            used_2_r    <= 1'b0;
        end else if (launch_s) begin
            stg_valid_r <= 1'b0;
            used_1_r    <= 1'b0;
            used_2_r    <= 1'b0;
        end else if (stg_avail_s && both_used_s) begin
            stg_valid_r <= 1'b0;
            used_1_r    <= 1'b0;
            used_2_r    <= 1'b0;
        end else begin
            if (pf_r == PF_WAIT) begin
                stg_valid_r <= 1'b1;
            end
            used_1_r <= used_1_r | consume_1_s;
            used_2_r <= used_2_r | consume_2_s;
        end
    end

    // Sticky protocol error, cleared by reset or an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (start_acc_s) begin
            err_r <= 1'b0;
        end else if (err_1_s || err_2_s) begin
            err_r <= 1'b1;
        end
    end

    bias_lane_tracker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane_1 (
        .clk           (clk),
        .rst           (rst),
        .run           (run_s),
        .init_load     (init_load_s),
        .init_val      (stage1_r),
        .rows_per_tile (rows_r),
        .num_tiles     (num_tiles_r),
        .sys_valid     (sys_valid_mon_1),
        .stg_avail     (avail_1_s),
        .stg_val       (stage1_r),
        .load_en       (bias_load_en_1),
        .bias_out      (bias_scalar_ub_out_1),
        .consume       (consume_1_s),
        .fin_next      (fin_1_s),
        .err_set       (err_1_s)
    );

    bias_lane_tracker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane_2 (
        .clk           (clk),
        .rst           (rst),
        .run           (run_s),
        .init_load     (init_load_s),
        .init_val      (ub_rd_data),
        .rows_per_tile (rows_r),
        .num_tiles     (num_tiles_r),
        .sys_valid     (sys_valid_mon_2),
        .stg_avail     (avail_2_s),
        .stg_val       (stg_val_2_s),
        .load_en       (bias_load_en_2),
        .bias_out      (bias_scalar_ub_out_2),
        .consume       (consume_2_s),
        .fin_next      (fin_2_s),
        .err_set       (err_2_s)
    );

    assign busy         = busy_r;
    assign done         = done_r;
    assign protocol_err = err_r;
    assign ub_rd_en     = rd_en_r;
    assign ub_rd_addr   = rd_addr_r;

endmodule

// File: tb/tb_bias_fetch_seq.sv
// Directed self-checking bench for bias_fetch_seq with a small UB memory model.
module tb_bias_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic [15:0] num_tiles = 16'h0000;
    logic [15:0] rows_per_tile = 16'h0000;
    logic        busy, done, protocol_err, ub_rd_en;
    logic [15:0] ub_rd_addr;
    logic [15:0] ub_rd_data = 16'h0000;
    logic        sys_valid_mon_1 = 1'b0;
    logic        sys_valid_mon_2 = 1'b0;
    logic [15:0] bias_scalar_ub_out_1, bias_scalar_ub_out_2;
    logic        bias_load_en_1, bias_load_en_2;

    always #5 clk = ~clk;

    bias_fetch_seq dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .base_addr            (base_addr),
        .num_tiles            (num_tiles),
        .rows_per_tile        (rows_per_tile),
        .busy                 (busy),
        .done                 (done),
        .protocol_err         (protocol_err),
        .ub_rd_en             (ub_rd_en),
        .ub_rd_addr           (ub_rd_addr),
        .ub_rd_data           (ub_rd_data),
        .sys_valid_mon_1      (sys_valid_mon_1),
        .sys_valid_mon_2      (sys_valid_mon_2),
        .bias_scalar_ub_out_1 (bias_scalar_ub_out_1),
        .bias_scalar_ub_out_2 (bias_scalar_ub_out_2),
        .bias_load_en_1       (bias_load_en_1),
        .bias_load_en_2       (bias_load_en_2)
    );

    // Unified Buffer model: one-cycle read latency
    logic [15:0] ub_mem [0:255];
    always @(posedge clk) ub_rd_data <= ub_rd_en ? ub_mem[ub_rd_addr[7:0]] : 16'h0000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs, indexed by cycle relative to the start cycle
    int c0 = 0;
    bit log_on = 1'b0;
    int rel_v;
    int ld1_rel[$], ld1_val[$], ld2_rel[$], ld2_val[$];
    int done_rel[$], rd_rel[$], rd_adr[$];
    logic busy_log [0:63];
    logic err_log  [0:63];

    always @(negedge clk) begin
        if (log_on) begin
            rel_v = cyc - c0;
            if (bias_load_en_1) begin ld1_rel.push_back(rel_v); ld1_val.push_back(int'(bias_scalar_ub_out_1)); end
            if (bias_load_en_2) begin ld2_rel.push_back(rel_v); ld2_val.push_back(int'(bias_scalar_ub_out_2)); end
            if (done) done_rel.push_back(rel_v);
            if (ub_rd_en) begin rd_rel.push_back(rel_v); rd_adr.push_back(int'(ub_rd_addr)); end
            if (rel_v >= 0 && rel_v < 64) begin
                busy_log[rel_v] = busy;
                err_log[rel_v]  = protocol_err;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    function automatic logic vpat(input int i, input int f, input int rows, input int gap, input int nvt);
        int d, p;
        if (nvt == 0 || i < f) return 1'b0;
        d = i - f;
        p = rows + gap;
        return ((d / p) < nvt) && ((d % p) < rows);
    endfunction

    task automatic exp_ld(input int lane, input int idx, input int rel, input int val);
        if (lane == 1) begin
            check_eq("ld1_cycle", q_at(ld1_rel, idx), rel);
            check_eq("ld1_value", q_at(ld1_val, idx), val);
        end else begin
            check_eq("ld2_cycle", q_at(ld2_rel, idx), rel);
            check_eq("ld2_value", q_at(ld2_val, idx), val);
        end
    endtask

    task automatic exp_rd(input int idx, input int rel, input int addr);
        check_eq("rd_cycle", q_at(rd_rel, idx), rel);
        check_eq("rd_addr", q_at(rd_adr, idx), addr);
    endtask

    // Drive one job from its start cycle; called right after a posedge
    task automatic run_job(input logic [15:0] base, input logic [15:0] nt, input logic [15:0] rows,
                           input int f1, input int f2, input int gap, input int nvt,
                           input int x1, input int x2, input int ncyc);
        ld1_rel.delete(); ld1_val.delete(); ld2_rel.delete(); ld2_val.delete();
        done_rel.delete(); rd_rel.delete(); rd_adr.delete();
        for (int i = 0; i < 64; i++) begin busy_log[i] = 1'b0; err_log[i] = 1'b0; end
        base_addr = base; num_tiles = nt; rows_per_tile = rows;
        c0 = cyc;
        log_on = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            start = (i == 0);
            sys_valid_mon_1 = vpat(i, f1, int'(rows), gap, nvt) | (i == x1);
            sys_valid_mon_2 = vpat(i, f2, int'(rows), gap, nvt) | (i == x2);
            @(posedge clk); #1;
        end
        start = 1'b0; sys_valid_mon_1 = 1'b0; sys_valid_mon_2 = 1'b0;
        log_on = 1'b0;
    endtask

    task automatic check_single_tile(input string tag);
        check_eq({tag, "_rd_count"}, rd_rel.size(), 2);
        exp_rd(0, 1, 16'h0100);
        exp_rd(1, 2, 16'h0101);
        check_eq({tag, "_ld1_count"}, ld1_rel.size(), 1);
        check_eq({tag, "_ld2_count"}, ld2_rel.size(), 1);
        exp_ld(1, 0, 4, 5);
        exp_ld(2, 0, 4, 32'h0000FFFD);
        check_eq({tag, "_done_count"}, done_rel.size(), 1);
        check_eq({tag, "_done_cycle"}, q_at(done_rel, 0), 10);
        check_eq({tag, "_busy_c1"}, busy_log[1], 1);
        check_eq({tag, "_busy_c9"}, busy_log[9], 1);
        check_eq({tag, "_busy_c10"}, busy_log[10], 0);
        check_eq({tag, "_err_end"}, err_log[13], 0);
    endtask

    int dcount, rcount, bsum;

    initial begin
        for (int i = 0; i < 256; i++) ub_mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {busy, done, protocol_err, ub_rd_en, ub_rd_addr, bias_scalar_ub_out_1,
                                bias_scalar_ub_out_2, bias_load_en_1, bias_load_en_2}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single tile
        ub_mem[8'h00] = 16'd5; ub_mem[8'h01] = 16'hFFFD;
        run_job(16'h0100, 16'd1, 16'd4, 5, 6, 2, 1, -1, -1, 14);
        check_single_tile("t1");

        // Three tiles with prefetch
        for (int i = 0; i < 6; i++) ub_mem[i] = 16'(i + 1);
        run_job(16'h0100, 16'd3, 16'd8, 5, 6, 2, 3, -1, -1, 40);
        check_eq("t2_rd_count", rd_rel.size(), 6);
        exp_rd(2, 5, 16'h0102); exp_rd(3, 6, 16'h0103);
        exp_rd(4, 15, 16'h0104); exp_rd(5, 16, 16'h0105);
        check_eq("t2_ld1_count", ld1_rel.size(), 3);
        check_eq("t2_ld2_count", ld2_rel.size(), 3);
        exp_ld(1, 0, 4, 1); exp_ld(1, 1, 13, 3); exp_ld(1, 2, 23, 5);
        exp_ld(2, 0, 4, 2); exp_ld(2, 1, 14, 4); exp_ld(2, 2, 24, 6);
        check_eq("t2_done_cycle", q_at(done_rel, 0), 34);
        check_eq("t2_err", err_log[39], 0);

        // Late staging: tile 0 ends before the prefetch lands
        run_job(16'h0100, 16'd2, 16'd1, 5, 5, 4, 2, -1, -1, 16);
        check_eq("t3_ld1_count", ld1_rel.size(), 2);
        check_eq("t3_ld2_count", ld2_rel.size(), 2);
        exp_ld(1, 1, 8, 3); exp_ld(2, 1, 8, 4);
        check_eq("t3_done_cycle", q_at(done_rel, 0), 11);
        check_eq("t3_err", err_log[15], 0);

        // Degenerate jobs
        run_job(16'h0100, 16'd0, 16'd4, 5, 6, 2, 0, -1, -1, 6);
        bsum = 0; for (int i = 0; i < 6; i++) bsum += int'(busy_log[i]);
        check_eq("t4a_done_cycle", q_at(done_rel, 0), 1);
        check_eq("t4a_done_count", done_rel.size(), 1);
        check_eq("t4a_rd_count", rd_rel.size(), 0);
        check_eq("t4a_busy", bsum, 0);
        run_job(16'h0100, 16'd2, 16'd0, 5, 6, 2, 0, -1, -1, 6);
        bsum = 0; for (int i = 0; i < 6; i++) bsum += int'(busy_log[i]);
        check_eq("t4b_done_cycle", q_at(done_rel, 0), 1);
        check_eq("t4b_rd_count", rd_rel.size(), 0);
        check_eq("t4b_busy", bsum, 0);

        // Protocol: valid on lane 1 during its load cycle
        run_job(16'h0100, 16'd2, 16'd8, 5, 6, 2, 2, 13, -1, 30);
        check_eq("t5a_err_c13", err_log[13], 0);
        check_eq("t5a_err_c14", err_log[14], 1);
        check_eq("t5a_err_held", err_log[29], 1);

        // Protocol: extra valid after lane 1 finished its last tile
        run_job(16'h0100, 16'd1, 16'd8, 5, 6, 2, 1, 13, -1, 24);
        check_eq("t5b_err_c13", err_log[13], 0);
        check_eq("t5b_err_c14", err_log[14], 1);
        check_eq("t5b_err_held", err_log[23], 1);
        check_eq("t5b_done_cycle", q_at(done_rel, 0), 14);

        // Error held up to the next accepted start, then cleared
        ub_mem[8'h00] = 16'd5; ub_mem[8'h01] = 16'hFFFD;
        run_job(16'h0100, 16'd1, 16'd4, 5, 6, 2, 1, -1, -1, 14);
        check_eq("t5_err_before_start", err_log[0], 1);
        check_eq("t5_err_after_start", err_log[1], 0);
        check_single_tile("t5c");

        // Reset in the middle of tile 1
        for (int i = 0; i < 6; i++) ub_mem[i] = 16'(i + 1);
        run_job(16'h0100, 16'd3, 16'd8, 5, 6, 2, 3, -1, -1, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t6_rst_outs", {busy, done, protocol_err, ub_rd_en, ub_rd_addr, bias_scalar_ub_out_1,
                                 bias_scalar_ub_out_2, bias_load_en_1, bias_load_en_2}, 64'd0);
        dcount = 0; rcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcount++;
            if (ub_rd_en) rcount++;
        end
        @(posedge clk); #1;
        check_eq("t6_no_done", dcount, 0);
        check_eq("t6_no_reads", rcount, 0);
        ub_mem[8'h00] = 16'd5; ub_mem[8'h01] = 16'hFFFD;
        run_job(16'h0100, 16'd1, 16'd4, 5, 6, 2, 1, -1, -1, 14);
        check_single_tile("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_fetch_seq.md
Name: bias_fetch_seq

Overview:
- Drives the bias load side of the two-column bias-add stage: `bias_scalar_ub_in_1/2` and `bias_load_en_1/2`.
- Fetches one bias per output column from the Unified Buffer, stages the biases for the next column pair, and pulses each column's load enable exactly when that column starts a new neuron tile.
- Tile boundaries are found by counting the systolic-array valid strobes, which this block monitors per lane.

Parameters:
- ADDR_W, 16, UB address width.
- DATA_W, 16, bias word width (signed).
- CNT_W, 16, width of the tile and row counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse; ignored while busy
- base_addr  in  ADDR_W  UB address of bias[0]
- num_tiles  in  CNT_W  number of column pairs (neuron tiles)
- rows_per_tile  in  CNT_W  valid outputs per lane per tile
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end
- protocol_err  out  1  sticky error flag; cleared by rst or an accepted start
- ub_rd_en  out  1  UB read strobe
- ub_rd_addr  out  ADDR_W  UB read address
- ub_rd_data  in  DATA_W  UB read data, valid the cycle after ub_rd_en
- sys_valid_mon_1  in  1  monitor copy of the lane-1 systolic valid
- sys_valid_mon_2  in  1  monitor copy of the lane-2 systolic valid
- bias_scalar_ub_out_1  out  DATA_W  bias for column 1; held stable between loads
- bias_scalar_ub_out_2  out  DATA_W  bias for column 2; held stable between loads
- bias_load_en_1  out  1  one-cycle load pulse for column 1
- bias_load_en_2  out  1  one-cycle load pulse for column 2

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, FSM in IDLE, staging empty.
- rst mid-job aborts immediately: no done pulse, no further reads.
- Tile t uses addr(t,1) = base_addr+2t and addr(t,2) = base_addr+2t+1. Addresses wrap modulo 2^ADDR_W.
- FSM states:
  - IDLE: start with num_tiles==0 or rows_per_tile==0 → done pulses at C+1 (C = start cycle); no reads, busy stays 0. Otherwise go to FETCH0.
  - FETCH0: ub_rd_en=1, addr(0,1) at C+1; addr(0,2) at C+2. Data is captured at C+2 and C+3.
  - ARM: at C+4, bias_load_en_1 and bias_load_en_2 pulse together. bias_scalar_ub_out_1/2 update in that same cycle. Row counters clear and state goes to RUN.
  - RUN: if tile t+1 < num_tiles and staging is empty, issue prefetch reads at the next two cycles. Staging becomes valid the cycle after the second data word.
  - DONE: entered when both lanes have finished the last tile. done pulses next cycle, busy drops, return to IDLE.
- Lane k in RUN, counting:
  - Each sys_valid_mon_k increments row_cnt_k.
  - A valid with row_cnt_k == rows_per_tile-1 ends lane k's tile and wraps row_cnt_k to 0.
- Lane k, loading the next tile:
  - If staging is valid, bias_load_en_k pulses the cycle after the tile-ending valid, with bias_scalar_ub_out_k = staged value.
  - If staging is not yet valid, set pending_k and pulse in the first cycle staging is valid.
  - Staging clears once both lanes have consumed it; the next prefetch may then start.
- Lanes are independent; lane 2 typically lags lane 1 by one cycle of systolic skew.
- Simultaneous events:
  - Both lanes ending in the same cycle → both loads pulse together.
  - Prefetch completing in the same cycle as a tile end → the load uses the newly staged value the following cycle.
- protocol_err is set on any of:
  - sys_valid_mon_k while not in RUN.
  - sys_valid_mon_k after lane k has finished its last tile.
  - sys_valid_mon_k in the load cycle, or while pending_k is set.
  
  The upstream controller must leave at least one cycle between tiles; the error does not stall the FSM.

Decomposition:
- Shared package bias_pkg holds:
  - DATA_W, ADDR_W, CNT_W defaults.
  - State enum {IDLE, FETCH0, ARM, RUN, DONE}.
  - Prefetch sub-state enum {PF_IDLE, PF_RD1, PF_RD2, PF_WAIT}.
- One natural sub-module: bias_lane_tracker, instantiated twice. It holds row_cnt, the finished-tile count, pending, load pulse generation and per-lane error detection.

Test Plan:
- Single tile (base=0x0100, UB[0x100]=5, UB[0x101]=-3, num_tiles=1, rows=4), start at C → reads at C+1/C+2; both load_en pulse at C+4 with outputs 5/-3; 4 valids per lane (lane 2 one cycle late) → done one cycle after the last lane-2 valid; no error.
- Three tiles (rows=8, UB[0x100..0x105]=1..6), 2-cycle gaps between tiles → loads deliver pairs (1,2), (3,4), (5,6); each lane's load lands the cycle after its 8th valid; lane skew is preserved.
- Late staging (rows=1, valid on each lane the cycle after ARM) → pending set; load_en_k pulses the cycle staging becomes valid (C+8); no error.
- Degenerate: num_tiles=0, then rows_per_tile=0 → done at C+1, ub_rd_en never asserted, busy stays 0.
- Protocol violation: valid on lane 1 in the cycle of load_en_1, and a 9th valid after the last tile → protocol_err=1 and held until the next accepted start.
- Reset mid-RUN (assert rst during tile 1) → next cycle all outputs 0, no done; a new start runs cleanly from FETCH0.
